// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue sequencer.
// State encoding, result width and quotient/remainder slice positions.
package div_issue_ctrl_pkg;

  localparam int DIV_DW     = 32;
  localparam int DIV_RES_WD = 2 * DIV_DW;
  localparam int QUOT_LSB   = DIV_DW;
  localparam int REM_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_axis_src_hold.sv
// Single AXI-stream source valid holder: raised on start,
// dropped on its own handshake, never re-raised until the next start.
module axis_src_hold (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tready,
  output logic tvalid
);

  logic tvalid_d, tvalid_q;

  always_comb begin
    tvalid_d = tvalid_q;
    if (start)
      tvalid_d = 1'b1;
    else if (tvalid_q && tready)
      tvalid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tvalid_q <= 1'b0;
    else
      tvalid_q <= tvalid_d;
  end

  assign tvalid = tvalid_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer between EXE and the signed/unsigned divider IPs:
// issues operands, collects the result, drains it on cancel.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic            req_signed,
  input  logic [DW-1:0]   req_src1,
  input  logic [DW-1:0]   req_src2,
  output logic            req_ready,
  input  logic            cancel,
  output logic            sdiv_dividend_tvalid,
  output logic            sdiv_divisor_tvalid,
  input  logic            sdiv_dividend_tready,
  input  logic            sdiv_divisor_tready,
  output logic            udiv_dividend_tvalid,
  output logic            udiv_divisor_tvalid,
  input  logic            udiv_dividend_tready,
  input  logic            udiv_divisor_tready,
  output logic [DW-1:0]   div_dividend_tdata,
  output logic [DW-1:0]   div_divisor_tdata,
  input  logic            sdiv_dout_tvalid,
  input  logic [2*DW-1:0] sdiv_dout_tdata,
  input  logic            udiv_dout_tvalid,
  input  logic [2*DW-1:0] udiv_dout_tdata,
  output logic            res_valid,
  output logic [DW-1:0]   res_quot,
  output logic [DW-1:0]   res_rem,
  output logic            res_dz,
  input  logic            res_ack,
  output logic            busy
);

  div_state_e    state_d, state_q;
  logic          signed_d, signed_q;
  logic [DW-1:0] src1_d, src1_q;
  logic [DW-1:0] src2_d, src2_q;
  logic [DW-1:0] quot_d, quot_q;
  logic [DW-1:0] rem_d, rem_q;
  logic          dz_d, dz_q;
  logic          csn_d, csn_q;

  logic            accept;
  logic            dvd_v, dvs_v;
  logic            dvd_rdy, dvs_rdy;
  logic            issue_done;
  logic            dout_v;
  logic [2*DW-1:0] dout;

  assign accept  = (state_q == S_IDLE) && req_valid && !cancel;
  assign dvd_rdy = signed_q ? sdiv_dividend_tready : udiv_dividend_tready;
  assign dvs_rdy = signed_q ? sdiv_divisor_tready : udiv_divisor_tready;
  assign dout_v  = signed_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
  assign dout    = signed_q ? sdiv_dout_tdata : udiv_dout_tdata;

  // A channel whose valid is already low has completed its handshake.
  assign issue_done = (!dvd_v || dvd_rdy) && (!dvs_v || dvs_rdy);

  axis_src_hold u_dvd (
    .clk    (clk),
    .rst_n  (resetn),
    .start  (accept),
    .tready (dvd_rdy),
    .tvalid (dvd_v)
  );

  axis_src_hold u_dvs (
    .clk    (clk),
    .rst_n  (resetn),
    .start  (accept),
    .tready (dvs_rdy),
    .tvalid (dvs_v)
  );

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dz_d     = dz_q;
    csn_d    = csn_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          signed_d = req_signed;
          src1_d   = req_src1;
          src2_d   = req_src2;
          dz_d     = (req_src2 == '0);
          csn_d    = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        csn_d = csn_q || cancel;
        if (issue_done)
          state_d = csn_d ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (dout_v && cancel) begin
          state_d = S_IDLE;
        end else if (dout_v) begin
          quot_d  = dout[QUOT_LSB +: DW];
          rem_d   = dout[REM_LSB +: DW];
          state_d = S_DONE;
        end else if (cancel) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (cancel || res_ack)
          state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dout_v)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      signed_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      csn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
      csn_q    <= csn_d;
    end
  end

  assign req_ready            = (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign res_valid            = (state_q == S_DONE);
  assign res_quot             = quot_q;
  assign res_rem              = rem_q;
  assign res_dz               = dz_q;
  assign div_dividend_tdata   = src1_q;
  assign div_divisor_tdata    = src2_q;
  assign sdiv_dividend_tvalid = dvd_v && signed_q;
  assign sdiv_divisor_tvalid  = dvs_v && signed_q;
  assign udiv_dividend_tvalid = dvd_v && !signed_q;
  assign udiv_divisor_tvalid  = dvs_v && !signed_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays both divider IPs.
module tb_div_issue_ctrl;

  localparam int DW = 32;

  logic          clk, resetn;
  logic          req_valid, req_signed, req_ready, cancel;
  logic [DW-1:0] req_src1, req_src2;
  logic          sdvd_v, sdvs_v, sdvd_r, sdvs_r;
  logic          udvd_v, udvs_v, udvd_r, udvs_r;
  logic [DW-1:0] dvd_data, dvs_data;
  logic          sdout_v, udout_v;
  logic [2*DW-1:0] sdout, udout;
  logic          res_valid, res_dz, res_ack, busy;
  logic [DW-1:0] res_quot, res_rem;

  int n_chk, n_fail;

  div_issue_ctrl #(.DW(DW)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .req_valid            (req_valid),
    .req_signed           (req_signed),
    .req_src1             (req_src1),
    .req_src2             (req_src2),
    .req_ready            (req_ready),
    .cancel               (cancel),
    .sdiv_dividend_tvalid (sdvd_v),
    .sdiv_divisor_tvalid  (sdvs_v),
    .sdiv_dividend_tready (sdvd_r),
    .sdiv_divisor_tready  (sdvs_r),
    .udiv_dividend_tvalid (udvd_v),
    .udiv_divisor_tvalid  (udvs_v),
    .udiv_dividend_tready (udvd_r),
    .udiv_divisor_tready  (udvs_r),
    .div_dividend_tdata   (dvd_data),
    .div_divisor_tdata    (dvs_data),
    .sdiv_dout_tvalid     (sdout_v),
    .sdiv_dout_tdata      (sdout),
    .udiv_dout_tvalid     (udout_v),
    .udiv_dout_tdata      (udout),
    .res_valid            (res_valid),
    .res_quot             (res_quot),
    .res_rem              (res_rem),
    .res_dz               (res_dz),
    .res_ack              (res_ack),
    .busy                 (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic s, input logic [DW-1:0] a,
                     input logic [DW-1:0] b);
    req_valid  = 1'b1;
    req_signed = s;
    req_src1   = a;
    req_src2   = b;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 1'b0;
    req_valid = 0; req_signed = 0; req_src1 = '0; req_src2 = '0;
    cancel = 0; res_ack = 0;
    sdvd_r = 0; sdvs_r = 0; udvd_r = 0; udvs_r = 0;
    sdout_v = 0; udout_v = 0; sdout = '0; udout = '0;

    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sdvd_v", sdvd_v, 0);
    chk("rst_udvs_v", udvs_v, 0);
    chk("rst_dz", res_dz, 0);
    chk("rst_quot", res_quot, 0);
    resetn = 1'b1;
    cyc();

    // 1: signed -7/2, readies high, result 12 cycles after accept
    req(1'b1, 32'hFFFF_FFF9, 32'd2);
    sdvd_r = 1; sdvs_r = 1;
    chk("t1_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    chk("t1_sdvd_v", sdvd_v, 1);
    chk("t1_sdvs_v", sdvs_v, 1);
    chk("t1_udvd_v", udvd_v, 0);
    chk("t1_udvs_v", udvs_v, 0);
    chk("t1_dvd_data", dvd_data, 32'hFFFF_FFF9);
    chk("t1_dvs_data", dvs_data, 32'd2);
    cyc();
    chk("t1_sdvd_drop", sdvd_v, 0);
    chk("t1_sdvs_drop", sdvs_v, 0);
    chk("t1_busy", busy, 1);
    for (int i = 3; i <= 11; i++) begin
      cyc();
      udout_v = (i == 5);
      udout = 64'h1234_5678_9ABC_DEF0;
    end
    chk("t1_no_early_res", res_valid, 0);
    sdout_v = 1;
    sdout = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    cyc();
    sdout_v = 0;
    sdout = '0;
    chk("t1_res_valid", res_valid, 1);
    chk("t1_quot", res_quot, 32'hFFFF_FFFD);
    chk("t1_rem", res_rem, 32'hFFFF_FFFF);
    chk("t1_dz", res_dz, 0);
    cyc();
    chk("t1_hold_valid", res_valid, 1);
    chk("t1_hold_quot", res_quot, 32'hFFFF_FFFD);
    res_ack = 1;
    cyc();
    res_ack = 0;
    chk("t1_ack_clr", res_valid, 0);
    chk("t1_ready_back", req_ready, 1);
    sdvd_r = 0; sdvs_r = 0;

    // 2: unsigned 100/7, divisor ready 3 cycles late
    req(1'b0, 32'd100, 32'd7);
    udvd_r = 1; udvs_r = 0;
    cyc();
    req_valid = 0;
    chk("t2_udvd_v", udvd_v, 1);
    chk("t2_udvs_v", udvs_v, 1);
    chk("t2_sdvd_v", sdvd_v, 0);
    chk("t2_sdvs_v", sdvs_v, 0);
    cyc();
    chk("t2_udvd_drop", udvd_v, 0);
    chk("t2_udvs_c2", udvs_v, 1);
    cyc();
    chk("t2_udvd_stay", udvd_v, 0);
    chk("t2_udvs_c3", udvs_v, 1);
    cyc();
    chk("t2_udvs_c4", udvs_v, 1);
    chk("t2_dvs_data", dvs_data, 32'd7);
    chk("t2_dvd_data", dvd_data, 32'd100);
    udvs_r = 1;
    cyc();
    chk("t2_udvs_drop", udvs_v, 0);
    chk("t2_wait_busy", busy, 1);
    udout_v = 1;
    udout = {32'd14, 32'd2};
    sdout_v = 1;
    sdout = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    cyc();
    udout_v = 0; sdout_v = 0;
    chk("t2_res_valid", res_valid, 1);
    chk("t2_quot", res_quot, 32'd14);
    chk("t2_rem", res_rem, 32'd2);
    res_ack = 1;
    cyc();
    res_ack = 0;
    chk("t2_ready_back", req_ready, 1);
    udvd_r = 0; udvs_r = 0;

    // 3: cancel in WAIT drains the next result
    req(1'b1, 32'd20, 32'd3);
    sdvd_r = 1; sdvs_r = 1;
    cyc();
    req_valid = 0;
    cyc();
    chk("t3_wait_busy", busy, 1);
    cancel = 1;
    cyc();
    cancel = 0;
    chk("t3_drain_ready", req_ready, 0);
    chk("t3_drain_busy", busy, 1);
    cyc();
    cyc();
    chk("t3_no_res", res_valid, 0);
    sdout_v = 1;
    sdout = {32'd6, 32'd2};
    cyc();
    sdout_v = 0;
    chk("t3_ready_back", req_ready, 1);
    chk("t3_no_res2", res_valid, 0);

    // 4: cancel mid-ISSUE, divisor still pending
    req(1'b1, 32'd9, 32'd4);
    sdvd_r = 1; sdvs_r = 0;
    cyc();
    req_valid = 0;
    cancel = 1;
    chk("t4_sdvs_v", sdvs_v, 1);
    cyc();
    cancel = 0;
    chk("t4_sdvd_drop", sdvd_v, 0);
    chk("t4_sdvs_held", sdvs_v, 1);
    cyc();
    chk("t4_sdvs_held2", sdvs_v, 1);
    chk("t4_busy", busy, 1);
    sdvs_r = 1;
    cyc();
    chk("t4_sdvs_drop", sdvs_v, 0);
    chk("t4_no_res", res_valid, 0);
    chk("t4_drain_ready", req_ready, 0);
    sdout_v = 1;
    sdout = {32'd2, 32'd1};
    cyc();
    sdout_v = 0;
    chk("t4_no_res2", res_valid, 0);
    chk("t4_ready_back", req_ready, 1);

    // 5: signed 5/0, ack and cancel together in DONE
    req(1'b1, 32'd5, 32'd0);
    sdvd_r = 1; sdvs_r = 1;
    cyc();
    req_valid = 0;
    cyc();
    sdout_v = 1;
    sdout = {32'hFFFF_FFFF, 32'd5};
    cyc();
    sdout_v = 0;
    chk("t5_res_valid", res_valid, 1);
    chk("t5_dz", res_dz, 1);
    chk("t5_rem", res_rem, 32'd5);
    res_ack = 1;
    cancel = 1;
    cyc();
    res_ack = 0;
    cancel = 0;
    chk("t5_res_clr", res_valid, 0);
    chk("t5_ready_back", req_ready, 1);
    sdvd_r = 0; sdvs_r = 0;

    // 6: async reset in WAIT, late result ignored
    req(1'b0, 32'd50, 32'd5);
    udvd_r = 1; udvs_r = 1;
    cyc();
    req_valid = 0;
    cyc();
    chk("t6_wait_busy", busy, 1);
    #2 resetn = 0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_udvd_v", udvd_v, 0);
    chk("t6_rst_udvs_v", udvs_v, 0);
    chk("t6_rst_dz", res_dz, 0);
    chk("t6_rst_dvd_data", dvd_data, 0);
    cyc();
    resetn = 1;
    udout_v = 1;
    udout = {32'd10, 32'd0};
    cyc();
    udout_v = 0;
    chk("t6_late_ignored", res_valid, 0);
    chk("t6_idle_ready", req_ready, 1);
    chk("t6_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
